delay_line_ctrl: RTL and testbench
==================================

Name: delay_line_ctrl

Overview:
- Multi-channel, valid-tagged delay line with a runtime-programmable depth, clock-enable stall and flush.
- Aligns CNN datapath side-band signals, e.g. window-valid or row-end flags, and aligns parallel feature-map lanes against pipelined MAC/pool stages whose latency is set at configuration time.
- Successor to the fixed single-width delay. Adds lane packing, valid tracking, stall, flush, bypass (depth 0) and runtime depth change.

Parameters:
- DATA_WIDTH, 16, bits per channel.
- NUM_CH, 1, number of parallel channels packed into one bus.
- MAX_DELAY, 8, number of physical register stages; legal range 1..64.
- DEFAULT_DELAY, MAX_DELAY, active depth after reset; range 0..MAX_DELAY.
- DLY_W, $clog2(MAX_DELAY+1), width of the depth fields (derived; not overridden).

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- en  in  1  advance enable; 0 = stall, so the line holds.
- flush  in  1  clears all in-flight valid tags.
- cfg_load  in  1  single-cycle strobe; loads cfg_delay.
- cfg_delay  in  DLY_W  requested depth.
- in_valid  in  1  input sample valid.
- in_data  in  NUM_CH*DATA_WIDTH  packed input; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  valid tag at the active tap.
- out_data  out  NUM_CH*DATA_WIDTH  data at the active tap.
- cur_delay  out  DLY_W  active depth.
- busy  out  1  at least one valid tag is in stages 1..cur_delay.
- cfg_err  out  1  one-cycle pulse when a rejected depth is loaded.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk. All state updates on the posedge of clk.
- Storage: stages S[1..MAX_DELAY]. Each stage holds {valid, data}.
- Shift rule (en=1, no flush, no accepted load): S[1] <= {in_valid, in_data}; S[k] <= S[k-1] for k=2..MAX_DELAY.
- Stall (en=0): all stages hold their value. in_valid and in_data are ignored, so the sample is not captured.
- Tap: for D = cur_delay ≥ 1, out_valid = S[D].valid and out_data = S[D].data, driven from registers.
- Bypass: for D = 0, out_valid = in_valid & en and out_data = in_data (combinational path).
- Transfer: a sample counts as consumed downstream only in a cycle with en=1.
- Latency: with en held at 1, a sample presented in cycle t appears on the output in cycle t+D. Stalled cycles add one cycle each.
- Data tags: data fields travel with their valid tag. Data under valid=0 is don't-care downstream but is still shifted.
- flush: all valid tags go to 0 on the next edge. Data is untouched and cur_delay is unchanged. A sample presented in the same cycle is dropped, even when en=1.
- cfg_load with cfg_delay ≤ MAX_DELAY:
  - cur_delay <= cfg_delay on the next edge.
  - All valid tags are cleared, giving an implicit flush. This prevents duplicated or skipped samples across a depth change.
  - The current input sample is dropped.
- cfg_load with cfg_delay > MAX_DELAY:
  - The load is ignored; cur_delay and the stages behave as if cfg_load were 0.
  - cfg_err = 1 for exactly the next cycle.
- Simultaneous events, in priority order: reset > cfg_load (accepted) > flush > en.
  - A rejected load and flush together: the flush still takes effect and cfg_err still pulses.
- busy = OR of S[k].valid for k=1..cur_delay. busy = 0 when cur_delay = 0.
- Reset values:
  - All stage data and valid tags = 0.
  - cur_delay = DEFAULT_DELAY.
  - out_valid = 0, cfg_err = 0, busy = 0.
  - out_data = 0 when DEFAULT_DELAY ≥ 1. When DEFAULT_DELAY = 0, out_data follows in_data.
- Reset mid-operation: in-flight samples are discarded without output.
- Elaboration: assertion fails if MAX_DELAY < 1 or DEFAULT_DELAY > MAX_DELAY.

Decomposition:
- Shared package lenet_pkg:
  - clog2-style width function.
  - Packed-lane slice helper (channel c offset = c*DATA_WIDTH).
  - Stage record typedef {valid, data}, if the package is parameterised.
- Sub-module delay_stage:
  - One {valid, data} register with en, clear_valid and reset.
  - Instantiated MAX_DELAY times with a generate loop.
- Top level holds the tap mux, cur_delay register, cfg logic and busy reduction.

Test Plan:
- Reset, then en=1 with MAX_DELAY=8, DEFAULT_DELAY=5, NUM_CH=2, 16-bit lanes, and a stream 0x0001/0x1001, 0x0002/0x1002, … → first out_valid=1 exactly 5 cycles after the first in_valid; lanes preserved; 20 samples in, 20 out in order.
- Stall: en=0 for 3 cycles mid-stream at D=5 → out_valid and out_data frozen while en=0; sample-to-output latency = 8 cycles for samples spanning the stall; no loss or duplication.
- Load cfg_delay=2 while 5 samples are in flight → the next cycle has cur_delay=2, busy=0, out_valid=0. A new sample at t appears at t+2. The 5 old samples never appear.
- Load cfg_delay=9 (MAX_DELAY=8) → cfg_err high for one cycle; cur_delay stays 5; stream continues unaffected.
- Load cfg_delay=0 → out_data equals in_data in the same cycle; out_valid = in_valid & en; busy=0.
- flush and in_valid=1 in the same cycle at D=3 → busy=0 next cycle; that sample and all earlier in-flight samples never appear; the following sample appears 3 cycles after entry. Then assert reset mid-stream → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared helpers for the LeNet datapath blocks: width math and lane packing.
package lenet_pkg;

    // Deepest delay line any block in this codebase is expected to build.
    localparam int unsigned MAX_DELAY_LIMIT = 64;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int unsigned clog2_w(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    // LSB position of channel ch inside a packed multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned ch, input int unsigned lane_w);
        return ch * lane_w;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One {valid, data} stage of the delay line; clearing the tag leaves the data alone.
module delay_stage #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear_valid,
    input  logic              d_valid,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [DATA_W-1:0] q_data
);

    // Valid tag: reset and clear win over shifting.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= 1'b0;
        end else if (clear_valid) begin
            q_valid <= 1'b0;
        end else if (en) begin
            q_valid <= d_valid;
        end
    end

    // Data field: held on clear so a flush never disturbs the payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_data <= '0;
        end else if (!clear_valid && en) begin
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Multi-lane valid-tagged delay line with programmable tap, stall, flush and bypass.
module delay_line_ctrl
    import lenet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned NUM_CH        = 1,
    parameter int unsigned MAX_DELAY     = 8,
    parameter int unsigned DEFAULT_DELAY = MAX_DELAY,
    localparam int unsigned DLY_W        = clog2_w(MAX_DELAY + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         cfg_load,
    input  logic [DLY_W-1:0]             cfg_delay,
    input  logic                         in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [DLY_W-1:0]             cur_delay,
    output logic                         busy,
    output logic                         cfg_err
);

    localparam int unsigned BUS_W = NUM_CH * DATA_WIDTH;

    // Parameter sanity, caught at elaboration.
    if (MAX_DELAY < 1 || MAX_DELAY > MAX_DELAY_LIMIT) begin : g_bad_max_delay
        $error("delay_line_ctrl: MAX_DELAY must be in 1..%0d", MAX_DELAY_LIMIT);
    end
    if (DEFAULT_DELAY > MAX_DELAY) begin : g_bad_default_delay
        $error("delay_line_ctrl: DEFAULT_DELAY must not exceed MAX_DELAY");
    end

    // Index 0 is the live input; 1..MAX_DELAY are the physical stages.
    logic [MAX_DELAY:0] stg_valid;
    logic [BUS_W-1:0]   stg_data [0:MAX_DELAY];

    logic               cfg_rej;
    logic               cfg_acc;
    logic               clear_valid;
    logic               tap_valid;
    logic [BUS_W-1:0]   tap_data;
    logic               busy_any;

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = in_data;

    // An accepted depth change doubles as a flush so nothing is skipped or duplicated.
    assign cfg_rej     = cfg_load && (cfg_delay > DLY_W'(MAX_DELAY));
    assign cfg_acc     = cfg_load && !cfg_rej;
    assign clear_valid = cfg_acc || flush;

    // Physical stage chain.
    for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
        delay_stage #(
            .DATA_W (BUS_W)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .en          (en),
            .clear_valid (clear_valid),
            .d_valid     (stg_valid[k-1]),
            .d_data      (stg_data[k-1]),
            .q_valid     (stg_valid[k]),
            .q_data      (stg_data[k])
        );
    end

    // Active depth register; rejected loads leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_delay <= DLY_W'(DEFAULT_DELAY);
        end else if (cfg_acc) begin
            cur_delay <= cfg_delay;
        end
    end

    // One-cycle error pulse for an out-of-range depth request.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_rej;
        end
    end

    // Tap select and occupancy reduction over stages 1..cur_delay.
    always_comb begin
        tap_valid = 1'b0;
        tap_data  = '0;
        busy_any  = 1'b0;
        for (int unsigned k = 1; k <= MAX_DELAY; k++) begin
            if (cur_delay == DLY_W'(k)) begin
                tap_valid = stg_valid[k];
                tap_data  = stg_data[k];
            end
            if (DLY_W'(k) <= cur_delay) begin
                busy_any = busy_any | stg_valid[k];
            end
        end
    end

    // Depth 0 is a straight combinational bypass; otherwise drive from the tap stage.
    always_comb begin
        if (cur_delay == '0) begin
            out_valid = in_valid & en;
            out_data  = in_data;
        end else begin
            out_valid = tap_valid;
            out_data  = tap_data;
        end
    end

    assign busy = busy_any;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Self-checking bench for delay_line_ctrl against an age-tracking sample model.
module tb_delay_line_ctrl;

    localparam int unsigned DW   = 16;
    localparam int unsigned NCH  = 2;
    localparam int unsigned MAXD = 8;
    localparam int unsigned DEFD = 5;

    logic        clk;
    logic        reset;
    logic        en;
    logic        flush;
    logic        cfg_load;
    logic [3:0]  cfg_delay;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  cur_delay;
    logic        busy;
    logic        cfg_err;

    delay_line_ctrl #(
        .DATA_WIDTH    (DW),
        .NUM_CH        (NCH),
        .MAX_DELAY     (MAXD),
        .DEFAULT_DELAY (DEFD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .cfg_load  (cfg_load),
        .cfg_delay (cfg_delay),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cur_delay (cur_delay),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each captured sample is remembered with the number of advancing edges since capture.
    typedef struct {
        logic        v;
        logic [31:0] d;
        int          age;
    } ent_t;

    ent_t q[$];
    int   m_cur;
    logic m_err;
    bit   model_ok;
    int   n_chk;
    int   n_fail;

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [31:0] ed;
        logic        eb;
        ev = 1'b0;
        ed = '0;
        eb = 1'b0;
        if (m_cur == 0) begin
            ev = in_valid & en;
            ed = in_data;
        end else begin
            foreach (q[i]) begin
                if (q[i].age == m_cur) begin
                    ev = q[i].v;
                    ed = q[i].d;
                end
                if (q[i].age <= m_cur && q[i].v) eb = 1'b1;
            end
        end
        chk1("out_valid", out_valid, ev);
        chk32("out_data", out_data, ed);
        chk1("busy", busy, eb);
        chk32("cur_delay", 32'(cur_delay), 32'(m_cur));
        chk1("cfg_err", cfg_err, m_err);
    endtask

    // Apply the effect of one clock edge to the model using the inputs now on the pins.
    task automatic model_edge();
        if (reset) begin
            q.delete();
            m_cur = DEFD;
            m_err = 1'b0;
        end else begin
            m_err = cfg_load && (int'(cfg_delay) > MAXD);
            if (cfg_load && int'(cfg_delay) <= MAXD) begin
                m_cur = int'(cfg_delay);
                foreach (q[i]) q[i].v = 1'b0;
            end else if (flush) begin
                foreach (q[i]) q[i].v = 1'b0;
            end else if (en) begin
                foreach (q[i]) q[i].age++;
                q.push_front('{v: in_valid, d: in_data, age: 1});
                while (q.size() > 0 && q[q.size()-1].age > int'(MAXD)) void'(q.pop_back());
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic e,
                        input logic fl, input logic ld, input logic [3:0] cd,
                        input logic rs);
        in_valid  = v;
        in_data   = d;
        en        = e;
        flush     = fl;
        cfg_load  = ld;
        cfg_delay = cd;
        reset     = rs;
        #4;
        if (model_ok) check_outputs();
        model_edge();
        if (rs) model_ok = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return {16'(16'h1000 + i), 16'(i)};
    endfunction

    task automatic run(input int v, input int d);
        step(1'(v), 32'(d), 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic load(input logic [3:0] cd, input logic v);
        step(v, $urandom, 1'b1, 1'b0, 1'b1, cd, 1'b0);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        model_ok = 1'b0;
        m_cur    = DEFD;
        m_err    = 1'b0;

        // Reset, then confirm reset values.
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk32("reset_out_data", out_data, 32'h0);
        chk1("reset_out_valid", out_valid, 1'b0);
        chk32("reset_cur_delay", 32'(cur_delay), 32'(DEFD));

        // 20-sample lane pattern at the default depth.
        for (int i = 1; i <= 20; i++) run(1, int'(pat(i)));
        idle(8);

        // Stall for three cycles mid-stream; input during stall is ignored.
        for (int i = 0; i < 13; i++) begin
            if (i >= 4 && i < 7) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
            else                 run(1, int'(pat(100 + i)));
        end
        idle(10);

        // Depth change to 2 with samples in flight.
        for (int i = 0; i < 5; i++) run(1, int'(pat(200 + i)));
        load(4'd2, 1'b1);
        chk32("load2_cur_delay", 32'(cur_delay), 32'd2);
        for (int i = 0; i < 6; i++) run(1, int'(pat(210 + i)));
        idle(4);

        // Back to 5, then a rejected request of 9 mid-stream.
        load(4'd5, 1'b0);
        for (int i = 0; i < 4; i++) run(1, int'(pat(300 + i)));
        load(4'd9, 1'b1);
        chk1("reject_err_pulse", cfg_err, 1'b1);
        for (int i = 0; i < 8; i++) run(1, int'(pat(310 + i)));
        idle(6);

        // Bypass.
        load(4'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'($urandom), $urandom, 1'($urandom), 1'b0, 1'b0, 4'd0, 1'b0);

        // Depth 3, flush while a sample is offered, then reset mid-stream.
        load(4'd3, 1'b0);
        for (int i = 0; i < 4; i++) run(1, int'(pat(400 + i)));
        step(1'b1, pat(404), 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk1("flush_busy", busy, 1'b0);
        for (int i = 0; i < 5; i++) run(1, int'(pat(410 + i)));
        step(1'b1, pat(420), 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        chk32("midreset_out_data", out_data, 32'h0);
        chk1("midreset_busy", busy, 1'b0);
        idle(6);

        // Randomised soak with occasional loads, flushes, stalls and resets.
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 4) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
